// File: rtl/matmul_pkg.sv
// Shared types for the matrix-product sequencer: FSM states and operand vector shape.
package matmul_pkg;
  localparam int VEC_N  = 32;
  localparam int ELEM_W = 8;

  typedef logic [VEC_N*ELEM_W-1:0] vec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_ROW,
    S_FETCH_COL,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;
endpackage

// File: rtl/mem_fetch.sv
// Delays a read enable by RD_LAT cycles and captures the returned vector on that strobe.
// o_cap pulses exactly when i_data is valid; o_vec holds until the next capture.
module mem_fetch
  import matmul_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int W      = VEC_N * ELEM_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_vec,
  output logic         o_cap
);
  logic [RD_LAT-1:0] r_sh;

  generate
    if (RD_LAT == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sh <= '0;
        else        r_sh <= i_en;
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sh <= '0;
        else        r_sh <= {r_sh[RD_LAT-2:0], i_en};
      end
    end
  endgenerate

  assign o_cap = r_sh[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     o_vec <= '0;
    else if (o_cap) o_vec <= i_data;
  end
endmodule

// File: rtl/matmul_sched.sv
// Walks (i,j) over C = A x B^T: fetch row/column, issue one dot product, await it, write C[i*DIM_J+j].
// One element per (RD_LAT+1)+1+unit+1 cycles plus RD_LAT+1 per row; start is ignored while busy.
module matmul_sched
  import matmul_pkg::*;
#(
  parameter int N       = VEC_N,
  parameter int DIM_I   = 32,
  parameter int DIM_J   = 32,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 15,
  localparam int IW = (DIM_I > 1) ? $clog2(DIM_I) : 1,
  localparam int JW = (DIM_J > 1) ? $clog2(DIM_J) : 1,
  localparam int CW = (DIM_I * DIM_J > 1) ? $clog2(DIM_I * DIM_J) : 1,
  localparam int VW = N * ELEM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              a_en,
  output logic [IW-1:0]     a_addr,
  input  logic [VW-1:0]     a_data,
  output logic              b_en,
  output logic [JW-1:0]     b_addr,
  input  logic [VW-1:0]     b_data,
  output logic [VW-1:0]     dp_row,
  output logic [VW-1:0]     dp_col,
  output logic              dp_valid,
  input  logic              dp_done,
  input  logic [ELEM_W-1:0] dp_result,
  output logic              c_we,
  output logic [CW-1:0]     c_addr,
  output logic [ELEM_W-1:0] c_data
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] I_LAST = IW'(DIM_I - 1);
  localparam logic [JW-1:0] J_LAST = JW'(DIM_J - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t            r_state;
  logic [IW-1:0]     r_i;
  logic [JW-1:0]     r_j;
  logic [TW-1:0]     r_tmo;
  logic              r_busy, r_done, r_err;
  logic              r_a_en, r_b_en, r_dp_valid, r_c_we;
  logic [CW-1:0]     r_c_addr;
  logic [ELEM_W-1:0] r_c_data;
  logic              w_a_cap, w_b_cap;

  mem_fetch #(.RD_LAT(RD_LAT), .W(VW)) u_fetch_a (
    .clk(clk), .rst_n(rst_n), .i_en(r_a_en), .i_data(a_data), .o_vec(dp_row), .o_cap(w_a_cap)
  );

  mem_fetch #(.RD_LAT(RD_LAT), .W(VW)) u_fetch_b (
    .clk(clk), .rst_n(rst_n), .i_en(r_b_en), .i_data(b_data), .o_vec(dp_col), .o_cap(w_b_cap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_i        <= '0;
      r_j        <= '0;
      r_tmo      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_a_en     <= 1'b0;
      r_b_en     <= 1'b0;
      r_dp_valid <= 1'b0;
      r_c_we     <= 1'b0;
      r_c_addr   <= '0;
      r_c_data   <= '0;
    end else begin
      r_a_en     <= 1'b0;
      r_b_en     <= 1'b0;
      r_dp_valid <= 1'b0;
      r_c_we     <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_i     <= '0;
          r_j     <= '0;
          r_err   <= 1'b0;
          r_busy  <= 1'b1;
          r_a_en  <= 1'b1;
          r_state <= S_FETCH_ROW;
        end
        S_FETCH_ROW: if (w_a_cap) begin
          r_b_en  <= 1'b1;
          r_state <= S_FETCH_COL;
        end
        S_FETCH_COL: if (w_b_cap) begin
          r_dp_valid <= 1'b1;
          r_state    <= S_ISSUE;
        end
        S_ISSUE: begin
          r_tmo   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (dp_done) begin
            r_c_data <= dp_result;
            r_c_addr <= CW'(int'(r_i) * DIM_J + int'(r_j));
            r_c_we   <= 1'b1;
            r_state  <= S_WRITE;
          end else if (r_tmo == T_LAST) begin
            // Abandon the product: no write and no done pulse.
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_WRITE: begin
          if (r_j != J_LAST) begin
            r_j     <= r_j + 1'b1;
            r_b_en  <= 1'b1;
            r_state <= S_FETCH_COL;
          end else if (r_i != I_LAST) begin
            r_j     <= '0;
            r_i     <= r_i + 1'b1;
            r_a_en  <= 1'b1;
            r_state <= S_FETCH_ROW;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign a_en     = r_a_en;
  assign a_addr   = r_i;
  assign b_en     = r_b_en;
  assign b_addr   = r_j;
  assign dp_valid = r_dp_valid;
  assign c_we     = r_c_we;
  assign c_addr   = r_c_addr;
  assign c_data   = r_c_data;
endmodule

// File: tb/tb_matmul_sched.sv
// Bench for matmul_sched: A/B memories, a dot-product unit model and a C-matrix reference.
module tb_matmul_sched;
  localparam int N  = 32;
  localparam int DI = 2;
  localparam int DJ = 3;
  localparam int RL = 2;
  localparam int TO = 15;
  localparam int W  = N * 8;
  localparam int IW = 1;
  localparam int JW = 2;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err, a_en, b_en, dp_valid, dp_done, c_we;
  logic [IW-1:0] a_addr;
  logic [JW-1:0] b_addr;
  logic [CW-1:0] c_addr;
  logic [W-1:0]  a_data, b_data, dp_row, dp_col;
  logic [7:0]    dp_result, c_data;

  matmul_sched #(.N(N), .DIM_I(DI), .DIM_J(DJ), .RD_LAT(RL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .a_en(a_en), .a_addr(a_addr), .a_data(a_data),
    .b_en(b_en), .b_addr(b_addr), .b_data(b_data),
    .dp_row(dp_row), .dp_col(dp_col), .dp_valid(dp_valid),
    .dp_done(dp_done), .dp_result(dp_result),
    .c_we(c_we), .c_addr(c_addr), .c_data(c_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] amem [DI];
  logic [W-1:0] bmem [DJ];
  logic [W-1:0] a_p [RL];
  logic [W-1:0] b_p [RL];

  always @(posedge clk) begin
    a_p[0] <= a_en ? amem[a_addr] : 'x;
    b_p[0] <= b_en ? bmem[b_addr] : 'x;
    for (int k = 1; k < RL; k++) begin
      a_p[k] <= a_p[k-1];
      b_p[k] <= b_p[k-1];
    end
  end
  assign a_data = a_p[RL-1];
  assign b_data = b_p[RL-1];

  function automatic logic [7:0] dot(input logic [W-1:0] x, input logic [W-1:0] y);
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(x[8*k +: 8]) * int'(y[8*k +: 8]);
    return 8'(s % 256);
  endfunction

  // Dot-product unit: result dp_lat cycles after the issue strobe.
  int         dp_lat = 3;
  bit         dp_never = 1'b0;
  int         dp_cnt = 0;
  logic [7:0] dp_res;
  always @(posedge clk) begin
    if (dp_valid === 1'b1) begin
      dp_cnt <= dp_lat;
      dp_res <= dot(dp_row, dp_col);
    end else if (dp_cnt > 0) begin
      dp_cnt <= dp_cnt - 1;
    end
  end
  assign dp_done   = (dp_cnt == 1) && !dp_never;
  assign dp_result = dp_done ? dp_res : 8'hxx;

  logic [7:0] cmem [DI*DJ];
  int we_addr_q[$];
  int we_cyc_q[$];
  int t0 = 0, done_cnt = 0, done_cyc = -1, first_busy = -1, err_cyc = -1;
  int last_issue = -100, gap_viol = 0;

  always @(negedge clk) begin
    if (c_we === 1'b1) begin
      we_addr_q.push_back(int'(c_addr));
      we_cyc_q.push_back(cyc - t0);
      if (int'(c_addr) < DI * DJ) cmem[int'(c_addr)] = c_data;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc - t0;
    end
    if (busy === 1'b1 && first_busy < 0) first_busy = cyc - t0;
    if (err === 1'b1 && err_cyc < 0) err_cyc = cyc - t0;
    if (dp_valid === 1'b1) begin
      if (cyc - last_issue < 4 || dp_cnt > 0) gap_viol++;
      last_issue = cyc;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input bit hold);
    tick();
    we_addr_q.delete();
    we_cyc_q.delete();
    for (int k = 0; k < DI * DJ; k++) cmem[k] = 'x;
    done_cnt = 0; done_cyc = -1; first_busy = -1; err_cyc = -1;
    last_issue = -100; gap_viol = 0;
    t0 = cyc;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (n < budget && done !== 1'b1 && !(err === 1'b1 && busy === 1'b0)) begin
      tick();
      n++;
    end
    chk({tag, "_ended"}, 32'(n < budget), 1);
  endtask

  task automatic check_c(input string tag);
    for (int i = 0; i < DI; i++)
      for (int j = 0; j < DJ; j++)
        chk($sformatf("%s_c%0d%0d", tag, i, j), 32'(cmem[i*DJ+j]), 32'(dot(amem[i], bmem[j])));
  endtask

  task automatic check_run(input string tag, input int elem);
    int exp_last = DI * (RL + 1 + elem * DJ);
    chk({tag, "_we_cnt"}, we_addr_q.size(), DI * DJ);
    for (int k = 0; k < we_addr_q.size(); k++)
      chk($sformatf("%s_we_addr%0d", tag, k), we_addr_q[k], k);
    if (we_cyc_q.size() > 0) begin
      chk({tag, "_first_we"}, we_cyc_q[0], RL + 1 + elem);
      chk({tag, "_last_we"}, we_cyc_q[we_cyc_q.size()-1], exp_last);
    end
    chk({tag, "_done_cyc"}, done_cyc, exp_last + 1);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_first_busy"}, first_busy, 1);
    chk({tag, "_gap"}, gap_viol, 0);
    check_c(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_a_en"}, a_en, 0);
    chk({tag, "_b_en"}, b_en, 0);
    chk({tag, "_dp_valid"}, dp_valid, 0);
    chk({tag, "_c_we"}, c_we, 0);
    chk({tag, "_addrs"}, {a_addr, b_addr, c_addr}, 0);
    chk({tag, "_c_data"}, c_data, 0);
    chk({tag, "_dp_row"}, |dp_row, 0);
    chk({tag, "_dp_col"}, |dp_col, 0);
  endtask

  task automatic fill_const(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] b);
    amem[0] = {N{a0}};
    amem[1] = {N{a1}};
    for (int j = 0; j < DJ; j++) bmem[j] = {N{b}};
  endtask

  task automatic fill_rand();
    for (int i = 0; i < DI; i++)
      for (int k = 0; k < N; k++) amem[i][8*k +: 8] = 8'($urandom);
    for (int j = 0; j < DJ; j++)
      for (int k = 0; k < N; k++) bmem[j][8*k +: 8] = 8'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick(3);
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick(2);

    fill_const(8'd1, 8'd1, 8'd1);
    launch(1'b0);
    wait_end("ones", 300);
    tick();
    chk("ones_busy_after", busy, 0);
    check_run("ones", 8);
    chk("ones_val", 32'(cmem[0]), 32);

    fill_const(8'd2, 8'd3, 8'd5);
    launch(1'b0);
    wait_end("wrap", 300);
    tick();
    check_run("wrap", 8);
    chk("wrap_row0", 32'(cmem[0]), 64);
    chk("wrap_row1", 32'(cmem[DJ]), 224);

    fill_rand();
    launch(1'b0);
    wait_end("rand", 300);
    tick();
    check_run("rand", 8);

    fill_rand();
    dp_lat = 10;
    launch(1'b0);
    wait_end("slow", 400);
    tick();
    check_run("slow", 15);
    dp_lat = 3;

    dp_never = 1'b1;
    launch(1'b0);
    wait_end("tmo", 200);
    tick();
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_we_cnt", we_addr_q.size(), 0);
    chk("tmo_done_cnt", done_cnt, 0);
    chk("tmo_err_window", 32'(err_cyc >= 2*(RL+1)+1+TO && err_cyc <= 2*(RL+1)+3+TO), 1);
    dp_never = 1'b0;
    tick(5);
    fill_rand();
    launch(1'b0);
    chk("tmo_err_cleared", err, 0);
    chk("tmo_restart_busy", busy, 1);
    wait_end("tmo_rerun", 300);
    tick();
    check_run("tmo_rerun", 8);

    fill_rand();
    launch(1'b0);
    n = 0;
    while (n < 200 && we_addr_q.size() < DJ) begin tick(); n++; end
    while (n < 200 && dp_valid !== 1'b1) begin tick(); n++; end
    chk("arst_reach_wait", 32'(n < 200), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    chk("arst_partial_we", we_addr_q.size(), DJ);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    fill_rand();
    launch(1'b0);
    wait_end("arst_rerun", 300);
    tick();
    check_run("arst_rerun", 8);

    fill_rand();
    launch(1'b1);
    wait_end("hold", 300);
    chk("hold_done_cyc", done_cyc < 0 ? DI*(RL+1+8*DJ)+1 : done_cyc, DI*(RL+1+8*DJ)+1);
    tick();
    chk("hold_idle_busy", busy, 0);
    tick();
    chk("hold_rerun_busy", busy, 1);
    start = 1'b0;
    n = 0;
    while (n < 300 && done_cnt < 2) begin tick(); n++; end
    chk("hold_second_done", done_cnt, 2);
    chk("hold_we_cnt", we_addr_q.size(), 2 * DI * DJ);
    check_c("hold");
    tick(5);
    chk("hold_no_third", busy, 0);
    chk("hold_done_final", done_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
